// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants, FSM states and access kinds for the memory access unit
package core_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_e;

  // True when exactly one of {store, load, fetch} is raised.
  function automatic logic strobe_onehot(input logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - wait-cycle counter that flags the last allowed REQ cycle
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W_RAW = $clog2(TIMEOUT + 1);
  localparam int W     = (W_RAW < 1) ? 1 : W_RAW;
  localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

  logic [W-1:0] cnt;

  // Clear on transaction accept, count every REQ cycle that passes without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // TIMEOUT of zero disables the abort entirely.
  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - turns fetch/load/store strobes into a held req/ack bus transaction
module mem_access_unit #(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter int              TIMEOUT  = 16,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(core_pkg::NOP_WORD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req,
  input  logic            load_req,
  input  logic            store_req,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] mdr,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ack
);

  import core_pkg::*;

  state_e     state;
  kind_e      kind;
  logic [2:0] strobes;
  logic       any_strobe;
  logic       legal_req;
  logic       cnt_clr;
  logic       cnt_en;
  logic       expired;

  assign strobes    = {store_req, load_req, fetch_req};
  assign any_strobe = |strobes;
  assign legal_req  = strobe_onehot(strobes) && (addr[1:0] == 2'b00);

  // The counter restarts on every accepted request and only advances while waiting.
  assign cnt_clr = (state == ST_IDLE) && legal_req;
  assign cnt_en  = (state == ST_REQ) && !bus_ack;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      kind      <= KIND_FETCH;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      ir        <= NOP_WORD;
      mdr       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_strobe) begin
            busy <= 1'b1;
            if (!legal_req) begin
              // Illegal request answers with an error pulse without touching the bus.
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= ST_REQ;
              bus_req   <= 1'b1;
              bus_we    <= store_req;
              bus_addr  <= {addr[XLEN-1:2], 2'b00};
              bus_wdata <= wdata;
              if (store_req) begin
                kind <= KIND_STORE;
              end else if (load_req) begin
                kind <= KIND_LOAD;
              end else begin
                kind <= KIND_FETCH;
              end
            end
          end
        end
        ST_REQ: begin
          // Ack wins over a timeout landing on the same cycle.
          if (bus_ack) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            done    <= 1'b1;
            case (kind)
              KIND_FETCH: ir  <= bus_rdata;
              KIND_LOAD:  mdr <= bus_rdata;
              default:    ;
            endcase
          end else if (expired) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench with a transaction-level model
module tb_mem_access_unit;

  localparam int          XLEN     = 32;
  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            fetch_req;
  logic            load_req;
  logic            store_req;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] mdr;
  logic            busy;
  logic            done;
  logic            err;
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_ack;

  int checks;
  int errors;

  logic [31:0] exp_ir;
  logic [31:0] exp_mdr;

  mem_access_unit #(
    .XLEN     (XLEN),
    .TIMEOUT  (TIMEOUT),
    .NOP_WORD (NOP_WORD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .load_req  (load_req),
    .store_req (store_req),
    .addr      (addr),
    .wdata     (wdata),
    .ir        (ir),
    .mdr       (mdr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One transaction: expected bus occupancy, completion cycle and error come from
  // the access rules (legality, ack delay d vs. TIMEOUT) computed with plain arithmetic.
  task automatic do_access(input logic [2:0] strb, input logic [31:0] a, input logic [31:0] wd,
                           input int d, input logic [31:0] rd, input bit busy_poke, input bit noise);
    bit   legal;
    bit   seen;
    int   exp_req;
    int   reqc;
    logic exp_err;
    legal = ($countones(strb) == 1) && (a[1:0] == 2'b00);
    if (!legal) begin
      exp_req = 0;
      exp_err = 1'b1;
    end else if (d < TIMEOUT) begin
      exp_req = d + 1;
      exp_err = 1'b0;
    end else begin
      exp_req = TIMEOUT;
      exp_err = 1'b1;
    end
    @(negedge clk);
    fetch_req = strb[0];
    load_req  = strb[1];
    store_req = strb[2];
    addr      = a;
    wdata     = wd;
    bus_ack   = 1'b0;
    reqc      = 0;
    seen      = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      fetch_req = 1'b0;
      load_req  = 1'b0;
      store_req = 1'b0;
      bus_ack   = 1'b0;
      if (bus_req) begin
        reqc++;
        check("bus_addr", bus_addr, a);
        check("bus_we", 32'(bus_we), 32'(strb[2]));
        if (strb[2]) check("bus_wdata", bus_wdata, wd);
        bus_ack   = (reqc - 1 == d);
        bus_rdata = (reqc - 1 == d) ? rd : $urandom;
      end else if (noise) begin
        bus_ack   = 1'($urandom % 2);
        bus_rdata = $urandom;
      end
      if (done) begin
        seen = 1'b1;
        check("done_cycle", 32'(c), 32'(exp_req + 1));
        check("err", 32'(err), 32'(exp_err));
        check("req_cycles", 32'(reqc), 32'(exp_req));
        check("busy_done", 32'(busy), 32'd1);
        if (legal && !exp_err) begin
          if (strb[0]) exp_ir  = rd;
          if (strb[1]) exp_mdr = rd;
        end
        check("ir", ir, exp_ir);
        check("mdr", mdr, exp_mdr);
      end else begin
        check("busy", 32'(busy), 32'd1);
        check("err_early", 32'(err), 32'd0);
      end
      if (busy_poke && c == 1) begin
        fetch_req = 1'b1;
        addr      = {$urandom} & ~32'd3;
      end
    end
    if (!seen) check("done_seen", 32'd0, 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    load_req  = 1'b0;
    store_req = 1'b0;
    bus_ack   = 1'b0;
    check("done_after", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("bus_req_after", 32'(bus_req), 32'd0);
  endtask

  initial begin
    logic [2:0]  strb;
    logic [31:0] a;
    logic [2:0]  multi [4];
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    fetch_req = 1'b0;
    load_req  = 1'b0;
    store_req = 1'b0;
    addr      = '0;
    wdata     = '0;
    bus_rdata = '0;
    bus_ack   = 1'b0;
    exp_ir    = NOP_WORD;
    exp_mdr   = 32'd0;
    multi[0] = 3'b011;
    multi[1] = 3'b101;
    multi[2] = 3'b110;
    multi[3] = 3'b111;

    repeat (3) @(negedge clk);
    check("rst_ir", ir, NOP_WORD);
    check("rst_mdr", mdr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    rst = 1'b0;

    do_access(3'b001, 32'h0000_0100, 32'd0, 0, 32'h0050_0093, 1'b0, 1'b0);
    do_access(3'b010, 32'h0000_2004, 32'd0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_access(3'b100, 32'h0000_2008, 32'h1234_5678, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
    do_access(3'b010, 32'h0000_2002, 32'd0, 0, 32'h1111_1111, 1'b0, 1'b0);
    do_access(3'b011, 32'h0000_2000, 32'd0, 0, 32'h2222_2222, 1'b0, 1'b0);
    do_access(3'b010, 32'h0000_3000, 32'd0, 1, 32'h3333_3333, 1'b1, 1'b1);
    do_access(3'b001, 32'h0000_0200, 32'd0, 10, 32'h4444_4444, 1'b0, 1'b0);
    do_access(3'b001, 32'h0000_0204, 32'd0, 3, 32'h5555_5555, 1'b0, 1'b0);

    // Reset while the bus request is outstanding.
    @(negedge clk);
    fetch_req = 1'b1;
    addr      = 32'h0000_0300;
    @(negedge clk);
    fetch_req = 1'b0;
    check("mid_bus_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_bus_req", 32'(bus_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ir", ir, NOP_WORD);
    check("mid_rst_mdr", mdr, 32'd0);
    check("mid_rst_bus_we", 32'(bus_we), 32'd0);
    exp_ir  = NOP_WORD;
    exp_mdr = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    do_access(3'b001, 32'h0000_0400, 32'd0, 1, 32'h00A0_0113, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom % 10 == 0) strb = multi[$urandom % 4];
      else                    strb = 3'b001 << ($urandom % 3);
      a = {$urandom} & ~32'd3;
      if ($urandom % 8 == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_access(strb, a, $urandom, $urandom_range(0, 5), $urandom,
                1'($urandom % 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
